sdram_burst_responder: RTL and testbench
========================================

# sdram_burst_responder

Synthesizable SDRAM-side responder that answers the burst write/read requests issued by `sys_fifo_ctrl`. It replaces the SDRAM core during FPGA bring-up and bench-level checks. It runs the init delay, row-activate latency, CAS latency and periodic refresh arbitration, and backs the data with on-chip RAM. It drives `init_end`, the per-beat acks, and the read data toward `sys_fifo_ctrl`.

## Interface
- `ADDR_W`, 24: width of the request address.
- `DATA_W`, 16: data word width.
- `BL_W`, 10: width of the burst length field.
- `MEM_AW`, 10: internal RAM address width. Only the low `MEM_AW` address bits are used.
- `INIT_CYCLES`, 16: number of cycles from reset release to `init_end`.
- `T_RCD`, 3: activate cycles between request acceptance and the first ack.
- `CAS_LAT`, 3: cycles from a read ack to its data. Must be ≥ 1.
- `REF_PERIOD`, 780: cycles between refresh requests.
- `REF_CYCLES`, 8: duration of one refresh.
- `sys_clk` in 1: system clock. One clock domain.
- `sys_rst` in 1: reset, synchronous, active-high.
- `init_end` out 1: high once initialization is complete; stays high until reset.
- `sdram_wr_req` in 1: write burst request. Held by the requester until its first ack.
- `sdram_wr_addr` in `ADDR_W`: write start word address.
- `sdram_wr_burst_len` in `BL_W`: write beats, 1..2^BL_W-1.
- `sdram_data_in` in `DATA_W`: write data. Valid in each `sdram_wr_ack` cycle (show-ahead FIFO).
- `sdram_wr_ack` out 1: one pulse-cycle per write beat.
- `sdram_rd_req` in 1: read burst request.
- `sdram_rd_addr` in `ADDR_W`: read start word address.
- `sdram_rd_burst_len` in `BL_W`: read beats.
- `sdram_rd_ack` out 1: one cycle per read beat issued.
- `sdram_data_valid` out 1: qualifies `sdram_data_out`.
- `sdram_data_out` out `DATA_W`: read data.
- `burst_err` out 1: sticky flag. Set when a request carries burst_len 0.

## Operation
- FSM states: INIT, IDLE, REF, ACT, WR, RD, DRAIN, PRE.
- INIT: counts `INIT_CYCLES`, then asserts `init_end` and goes to IDLE.
- IDLE arbitration, evaluated once per cycle:
  - A pending refresh has priority, then write, then read.
  - Simultaneous write and read requests: the write is served first; the read is taken at the next IDLE.
- Request acceptance:
  - Address, length and direction are latched in the accepting cycle.
  - Request inputs are ignored outside IDLE.
  - Deasserting a request mid-burst has no effect; the burst always completes.
- burst_len 0: the request is not accepted and no ack is generated. `burst_err` is set, and the FSM stays in IDLE with the other request still eligible.
- ACT: lasts `T_RCD` cycles, then moves to WR or RD.
- WR:
  - `sdram_wr_ack` is high for exactly burst_len consecutive cycles.
  - Beat k writes `sdram_data_in` to RAM[(addr+k) mod 2^MEM_AW]. The address wraps silently.
- RD:
  - `sdram_rd_ack` is high for burst_len consecutive cycles.
  - Beat k reads RAM[(addr+k) mod 2^MEM_AW].
  - The data leaves through a `CAS_LAT`-deep valid/data pipe.
- DRAIN: waits until the last `sdram_data_valid` has been output.
- PRE: one cycle, then IDLE.
- REF: lasts `REF_CYCLES` cycles, then IDLE.
- Refresh timer:
  - Free-runs once `init_end` is high and reloads to `REF_PERIOD` on expiry.
  - Expiry sets `ref_pending`. It never interrupts a burst; it is served at the next IDLE and cleared on entry to REF.
  - If a second expiry occurs while one is pending, the requests merge into one refresh.
- RAM contents are not cleared by reset.

## Timing
- Reset values: `init_end`, `sdram_wr_ack`, `sdram_rd_ack`, `sdram_data_valid` and `burst_err` are 0; `sdram_data_out` is 0. The FSM is in INIT and the read pipe is flushed.
- Reset mid-operation: the burst aborts at the next edge, with no further acks or valids. INIT reruns in full.
- Request sampled in IDLE at cycle t → first ack at cycle t+1+`T_RCD`.
- Read ack at cycle c → `sdram_data_valid` and its data at cycle c+`CAS_LAT`. Valid cycles are contiguous.
- Write burst turnaround:
  - Last ack at cycle c → PRE at c+1 → IDLE at c+2.
  - The earliest next acceptance is at c+2.
- Read burst turnaround: last valid at cycle v → PRE at v+1 → IDLE at v+2.
- `init_end` rises `INIT_CYCLES` cycles after the first cycle with `sys_rst` low.

## Structure
- Package `sdram_resp_pkg` holds the state enum `resp_state_t`, the default width constants, and a `beat_cnt_t` typedef (`BL_W` bits).
- Sub-module `sdram_resp_mem`: single-port synchronous RAM with a registered read (1 cycle).
  - The top level adds `CAS_LAT`-1 delay stages for data and valid.
  - Writes and reads are never concurrent, so a single port is sufficient.

## Test plan
- Reset release: `init_end` is 0 for 16 cycles, then 1. No ack fires before `init_end`.
- Write of 8 beats to address 0x000010 with data 0xA000..0xA007: first ack 4 cycles after request acceptance, followed by 8 contiguous ack cycles. A following 8-beat read of the same address returns 0xA000..0xA007 with `sdram_data_valid` 3 cycles after each `sdram_rd_ack`.
- Write and read requests raised in the same cycle: the write burst completes first, then the read is accepted at the next IDLE and returns the written data.
- Refresh timer expires during a 64-beat write: the burst is not interrupted. REF lasts 8 cycles right after PRE, and only then is a pending read accepted.
- Write at address 0x0003FE with length 4: RAM words 0x3FE, 0x3FF, 0x000 and 0x001 are written (wrap-around). A read at 0x0003FE with length 4 returns the same data.
- burst_len 0 request: no ack and `burst_err` latches to 1. `sys_rst` asserted in the middle of a read: valids stop at the next edge and INIT reruns.

Source files
------------

// File: rtl/sdram_resp_pkg.sv
// Shared state encoding, default sizing and helper types for the SDRAM burst responder.
package sdram_resp_pkg;

    localparam int unsigned DefAddrW = 24;
    localparam int unsigned DefDataW = 16;
    localparam int unsigned DefBlW   = 10;
    localparam int unsigned DefMemAw = 10;
    // Shared phase timer width; covers the init, activate and refresh delays.
    localparam int unsigned TmrW     = 16;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StRef,
        StAct,
        StWr,
        StRd,
        StDrain,
        StPre
    } resp_state_t;

    typedef logic [DefBlW-1:0] beat_cnt_t;

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port synchronous RAM with a registered read; the array itself is never reset.
module sdram_resp_mem #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned MEM_AW = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**MEM_AW];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = mem_q[addr_i];
    end

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sdram_burst_responder.sv
// SDRAM stand-in answering sys_fifo_ctrl bursts: init delay, tRCD, CAS latency and
// refresh arbitration around an on-chip RAM.
module sdram_burst_responder
    import sdram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned BL_W        = DefBlW,
    parameter int unsigned MEM_AW      = DefMemAw,
    parameter int unsigned INIT_CYCLES = 16,
    parameter int unsigned T_RCD       = 3,
    parameter int unsigned CAS_LAT     = 3,
    parameter int unsigned REF_PERIOD  = 780,
    parameter int unsigned REF_CYCLES  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              init_end,
    input  logic              sdram_wr_req,
    input  logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic [BL_W-1:0]   sdram_wr_burst_len,
    input  logic [DATA_W-1:0] sdram_data_in,
    output logic              sdram_wr_ack,
    input  logic              sdram_rd_req,
    input  logic [ADDR_W-1:0] sdram_rd_addr,
    input  logic [BL_W-1:0]   sdram_rd_burst_len,
    output logic              sdram_rd_ack,
    output logic              sdram_data_valid,
    output logic [DATA_W-1:0] sdram_data_out,
    output logic              burst_err
);

    localparam int unsigned RefW = $clog2(REF_PERIOD + 1);

    resp_state_t       state_q, state_d;
    logic [TmrW-1:0]   tmr_q, tmr_d;
    logic [BL_W-1:0]   beat_q, beat_d;
    logic [BL_W-1:0]   len_q, len_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic              is_wr_q, is_wr_d;
    logic              init_end_q, init_end_d;
    logic              err_q, err_d;
    logic [RefW-1:0]   ref_tmr_q, ref_tmr_d;
    logic              ref_pend_q, ref_pend_d;
    logic [CAS_LAT-1:0] vld_q, vld_d;

    logic              wr_ok, rd_ok, enter_ref, ref_expire;
    logic [MEM_AW-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^{sdram_wr_addr[ADDR_W-1:MEM_AW], sdram_rd_addr[ADDR_W-1:MEM_AW]};

    assign wr_ok = sdram_wr_req && (sdram_wr_burst_len != '0);
    assign rd_ok = sdram_rd_req && (sdram_rd_burst_len != '0);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        beat_d     = beat_q;
        len_d      = len_q;
        addr_d     = addr_q;
        is_wr_d    = is_wr_q;
        init_end_d = init_end_q;
        err_d      = err_q;
        enter_ref  = 1'b0;
        unique case (state_q)
            StInit: begin
                if (tmr_q == TmrW'(INIT_CYCLES - 1)) begin
                    init_end_d = 1'b1;
                    tmr_d      = '0;
                    state_d    = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StIdle: begin
                tmr_d  = '0;
                beat_d = '0;
                if (ref_pend_q) begin
                    enter_ref = 1'b1;
                    state_d   = StRef;
                end else begin
                    // A zero-length request is flagged and skipped so the other one may still go.
                    if (sdram_wr_req && (sdram_wr_burst_len == '0)) err_d = 1'b1;
                    if (!wr_ok && sdram_rd_req && (sdram_rd_burst_len == '0)) err_d = 1'b1;
                    if (wr_ok) begin
                        addr_d  = sdram_wr_addr[MEM_AW-1:0];
                        len_d   = sdram_wr_burst_len;
                        is_wr_d = 1'b1;
                        state_d = StAct;
                    end else if (rd_ok) begin
                        addr_d  = sdram_rd_addr[MEM_AW-1:0];
                        len_d   = sdram_rd_burst_len;
                        is_wr_d = 1'b0;
                        state_d = StAct;
                    end
                end
            end
            StAct: begin
                if (tmr_q == TmrW'(T_RCD - 1)) begin
                    tmr_d   = '0;
                    state_d = is_wr_q ? StWr : StRd;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StWr: begin
                if (beat_q == len_q - 1'b1) state_d = StPre;
                else                        beat_d  = beat_q + 1'b1;
            end
            StRd: begin
                if (beat_q == len_q - 1'b1) state_d = StDrain;
                else                        beat_d  = beat_q + 1'b1;
            end
            StDrain: begin
                // Last valid is leaving when only the top pipe stage is occupied.
                if (vld_q[CAS_LAT-1] && ((vld_q << 1) == '0)) state_d = StPre;
            end
            StPre: begin
                state_d = StIdle;
            end
            StRef: begin
                if (tmr_q == TmrW'(REF_CYCLES - 1)) begin
                    tmr_d   = '0;
                    state_d = StIdle;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = StInit;
        endcase
    end

    assign ref_expire = init_end_q && (ref_tmr_q == '0);

    always_comb begin
        ref_tmr_d = ref_tmr_q;
        if (init_end_q) begin
            ref_tmr_d = ref_expire ? RefW'(REF_PERIOD - 1) : ref_tmr_q - 1'b1;
        end
        // Expiries arriving while one is pending merge into a single refresh.
        ref_pend_d = (ref_pend_q && !enter_ref) || ref_expire;
    end

    assign sdram_wr_ack = (state_q == StWr);
    assign sdram_rd_ack = (state_q == StRd);

    always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = sdram_rd_ack;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= StInit;
            tmr_q      <= '0;
            beat_q     <= '0;
            len_q      <= '0;
            addr_q     <= '0;
            is_wr_q    <= 1'b0;
            init_end_q <= 1'b0;
            err_q      <= 1'b0;
            ref_tmr_q  <= RefW'(REF_PERIOD - 1);
            ref_pend_q <= 1'b0;
            vld_q      <= '0;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            beat_q     <= beat_d;
            len_q      <= len_d;
            addr_q     <= addr_d;
            is_wr_q    <= is_wr_d;
            init_end_q <= init_end_d;
            err_q      <= err_d;
            ref_tmr_q  <= ref_tmr_d;
            ref_pend_q <= ref_pend_d;
            vld_q      <= vld_d;
        end
    end

    assign mem_addr = addr_q + MEM_AW'(beat_q);

    sdram_resp_mem #(
        .DATA_W (DATA_W),
        .MEM_AW (MEM_AW)
    ) u_mem (
        .clk_i   (sys_clk),
        .rst_i   (sys_rst),
        .we_i    (sdram_wr_ack),
        .addr_i  (mem_addr),
        .wdata_i (sdram_data_in),
        .rdata_o (mem_rdata)
    );

    // The RAM read register is the first CAS stage; the rest are added here.
    generate
        if (CAS_LAT > 1) begin : g_dpipe
            logic [DATA_W-1:0] dpipe_q [CAS_LAT-1];
            logic [DATA_W-1:0] dpipe_d [CAS_LAT-1];
            always_comb begin
                dpipe_d[0] = mem_rdata;
                for (int unsigned i = 1; i < CAS_LAT - 1; i++) begin
                    dpipe_d[i] = dpipe_q[i-1];
                end
            end
            always_ff @(posedge sys_clk) begin
                if (sys_rst) begin
                    for (int unsigned i = 0; i < CAS_LAT - 1; i++) begin
                        dpipe_q[i] <= '0;
                    end
                end else begin
                    dpipe_q <= dpipe_d;
                end
            end
            assign sdram_data_out = dpipe_q[CAS_LAT-2];
        end else begin : g_nopipe
            assign sdram_data_out = mem_rdata;
        end
    endgenerate

    assign sdram_data_valid = vld_q[CAS_LAT-1];
    assign init_end         = init_end_q;
    assign burst_err        = err_q;

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Scoreboard bench: bursts push expected read data; a negedge monitor pops and compares.
module tb_sdram_burst_responder;

    localparam int INIT_CYCLES = 16;
    localparam int CAS_LAT     = 3;
    localparam int MEM_WORDS   = 1024;
    localparam int BUDGET      = 4000;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        init_end;
    logic        sdram_wr_req = 1'b0;
    logic [23:0] sdram_wr_addr = '0;
    logic [9:0]  sdram_wr_burst_len = '0;
    logic [15:0] sdram_data_in = '0;
    logic        sdram_wr_ack;
    logic        sdram_rd_req = 1'b0;
    logic [23:0] sdram_rd_addr = '0;
    logic [9:0]  sdram_rd_burst_len = '0;
    logic        sdram_rd_ack;
    logic        sdram_data_valid;
    logic [15:0] sdram_data_out;
    logic        burst_err;

    sdram_burst_responder dut (
        .sys_clk            (clk),
        .sys_rst            (sys_rst),
        .init_end           (init_end),
        .sdram_wr_req       (sdram_wr_req),
        .sdram_wr_addr      (sdram_wr_addr),
        .sdram_wr_burst_len (sdram_wr_burst_len),
        .sdram_data_in      (sdram_data_in),
        .sdram_wr_ack       (sdram_wr_ack),
        .sdram_rd_req       (sdram_rd_req),
        .sdram_rd_addr      (sdram_rd_addr),
        .sdram_rd_burst_len (sdram_rd_burst_len),
        .sdram_rd_ack       (sdram_rd_ack),
        .sdram_data_valid   (sdram_data_valid),
        .sdram_data_out     (sdram_data_out),
        .burst_err          (burst_err)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] model [MEM_WORDS];
    logic [15:0] wq[$];
    logic [15:0] expq[$];
    int          ack_t[$];

    int wr_cnt = 0, wr_last = -10, wr_run_start = 0;
    int rd_cnt = 0, rd_last = -10, rd_run_start = 0;
    int vld_cnt = 0;
    int since_rel = 0, init_rise = 0;
    bit init_seen = 0, ack_pre_init = 0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (sys_rst) begin
            since_rel    = 0;
            init_seen    = 0;
            ack_pre_init = 0;
        end else begin
            if (!init_end && (sdram_wr_ack || sdram_rd_ack)) ack_pre_init = 1;
            if (init_end && !init_seen) begin
                init_seen = 1;
                init_rise = cyc;
                chk("init_end_delay", since_rel, INIT_CYCLES);
                chk("no_ack_before_init", ack_pre_init, 0);
            end
            since_rel++;
        end
        if (sdram_wr_ack) begin
            if (cyc != wr_last + 1) wr_run_start = cyc;
            wr_last = cyc;
            wr_cnt++;
            if (wq.size() == 0) chk("wr_ack_unexpected", 1, 0);
            else sdram_data_in = wq.pop_front();
        end
        if (sdram_rd_ack) begin
            if (cyc != rd_last + 1) rd_run_start = cyc;
            rd_last = cyc;
            rd_cnt++;
            ack_t.push_back(cyc);
        end
        if (sdram_data_valid) begin
            vld_cnt++;
            if (expq.size() == 0 || ack_t.size() == 0) begin
                chk("rd_valid_unexpected", 1, 0);
            end else begin
                chk("rd_data", sdram_data_out, expq.pop_front());
                chk("rd_cas_latency", cyc - ack_t.pop_front(), CAS_LAT);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) next_cycle();
    endtask

    // Issues a write and/or read (write served first); zw raises a zero-length write.
    task automatic burst(input bit dw, input int wa, input int wl, input bit zw,
                         input bit dr, input int ra, input int rl,
                         input bit rnd, input logic [15:0] base,
                         input int wlat, input int rlat);
        int t0, wc0, rc0, n;
        bit done;
        logic [15:0] d;
        wc0 = wr_cnt;
        rc0 = rd_cnt;
        if (dw) begin
            for (int k = 0; k < wl; k++) begin
                d = rnd ? 16'($urandom) : base + 16'(k);
                model[(wa + k) % MEM_WORDS] = d;
                wq.push_back(d);
            end
        end
        if (dr) begin
            for (int k = 0; k < rl; k++) expq.push_back(model[(ra + k) % MEM_WORDS]);
        end
        sdram_wr_req       = dw | zw;
        sdram_wr_addr      = 24'(wa);
        sdram_wr_burst_len = zw ? 10'd0 : 10'(wl);
        sdram_rd_req       = dr;
        sdram_rd_addr      = 24'(ra);
        sdram_rd_burst_len = 10'(rl);
        t0 = cyc;
        n = 0;
        done = 0;
        while (!done && n < BUDGET) begin
            next_cycle();
            n++;
            if (wr_cnt != wc0) sdram_wr_req = 1'b0;
            if (rd_cnt != rc0) sdram_rd_req = 1'b0;
            done = (!dw || wr_cnt - wc0 >= wl) && (!dr || rd_cnt - rc0 >= rl) &&
                   wq.size() == 0 && expq.size() == 0;
        end
        sdram_wr_req = 1'b0;
        sdram_rd_req = 1'b0;
        chk("burst_complete", done, 1);
        if (!done) begin
            wq.delete();
            expq.delete();
            ack_t.delete();
        end
        if (dw) begin
            chk("wr_ack_count", wr_cnt - wc0, wl);
            chk("wr_ack_contiguous", wr_last - wr_run_start + 1, wl);
            if (wlat > 0) chk("wr_first_ack_latency", wr_run_start - t0, wlat);
        end
        if (dr) begin
            chk("rd_ack_count", rd_cnt - rc0, rl);
            chk("rd_ack_contiguous", rd_last - rd_run_start + 1, rl);
            if (rlat > 0) chk("rd_first_ack_latency", rd_run_start - t0, rlat);
        end
    endtask

    initial begin
        idle(3);
        chk("reset_outputs", {init_end, sdram_wr_ack, sdram_rd_ack, sdram_data_valid,
                              burst_err, sdram_data_out}, 0);
        // Write raised during INIT is only accepted once IDLE is reached.
        sys_rst = 1'b0;
        burst(1, 'h20, 2, 0, 0, 0, 0, 0, 16'h5550, INIT_CYCLES + 4, 0);
        idle(1);
        burst(1, 'h10, 8, 0, 0, 0, 0, 0, 16'hA000, 4, 0);
        // Raised during PRE: accepted one cycle later.
        burst(0, 0, 0, 0, 1, 'h10, 8, 0, 16'h0, 0, 5);
        burst(1, 'h3FE, 4, 0, 0, 0, 0, 0, 16'hC000, 5, 0);
        idle(1);
        burst(0, 0, 0, 0, 1, 'h3FE, 4, 0, 16'h0, 0, 4);
        chk("wrap_word_0x000", model[0], 16'hC002);
        idle(1);
        burst(1, 'h100, 5, 0, 1, 'h100, 5, 0, 16'hB000, 4, 14);
        idle(1);
        chk("burst_err_clear", burst_err, 0);
        burst(0, 0, 0, 1, 1, 'h10, 3, 0, 16'h0, 0, 4);
        chk("burst_err_set", burst_err, 1);

        // 64-beat write spans the first refresh expiry; the read waits out PRE, IDLE, REF.
        while (cyc < init_rise + 740) next_cycle();
        burst(1, 'h300, 64, 0, 1, 'h300, 64, 1, 16'h0, 4, 82);

        idle(1);
        burst(1, 0, 512, 0, 0, 0, 0, 1, 16'h0, 0, 0);
        burst(1, 512, 512, 0, 0, 0, 0, 1, 16'h0, 0, 0);
        for (int it = 0; it < 25; it++) begin
            int mode, wa, ra, wl, rl;
            mode = $urandom_range(0, 2);
            wa = $urandom_range(0, 24'hFFFFFF);
            wl = $urandom_range(1, 40);
            rl = $urandom_range(1, 40);
            ra = ($urandom_range(0, 1) == 1) ? wa : $urandom_range(0, 24'hFFFFFF);
            burst(mode != 1, wa, wl, 0, mode != 0, ra, rl, 1, 16'h0, 0, 0);
            idle($urandom_range(0, 3));
        end

        // Reset in the middle of a read burst.
        idle(1);
        for (int k = 0; k < 30; k++) expq.push_back(model[('h200 + k) % MEM_WORDS]);
        begin
            int v0, n;
            v0 = vld_cnt;
            n = 0;
            sdram_rd_addr = 24'h200;
            sdram_rd_burst_len = 10'd30;
            sdram_rd_req = 1'b1;
            while (vld_cnt - v0 < 5 && n < 200) begin
                next_cycle();
                n++;
            end
            chk("mid_read_valids_seen", vld_cnt - v0 >= 5, 1);
        end
        sys_rst = 1'b1;
        sdram_rd_req = 1'b0;
        next_cycle();
        expq.delete();
        ack_t.delete();
        chk("reset_stops_burst", {sdram_rd_ack, sdram_data_valid, init_end, sdram_data_out}, 0);
        idle(3);
        sys_rst = 1'b0;
        begin
            int n;
            n = 0;
            while (!init_end && n < 40) begin
                next_cycle();
                n++;
            end
            chk("init_after_reset", init_end, 1);
        end
        // RAM contents survive reset.
        burst(0, 0, 0, 0, 1, 'h10, 8, 0, 16'h0, 0, 0);
        idle(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
